// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
// Shared definitions for the I2C command sequencer: FSM state encodings,
// the host command word layout, the word width and the NACK retry limit.
// No ports; imported by the sequencer top and its FIFO.
package i2c_seq_pkg;

  localparam int CMD_W = 32;

  // Number of re-issues allowed after a NACK when retries are enabled.
  localparam int RETRY_LIMIT = 2;

  // Sequencer states, encoded as presented on seq_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_RUN   = 3'd2,
    ST_GAP   = 3'd3,
    ST_ERROR = 3'd4
  } seq_state_e;

  // Host command word: [31:24] device address byte, [23:16] register
  // address, [15:8] data byte, [7:0] engine control bits.
  typedef struct packed {
    logic [7:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
    logic [7:0] ctrl;
  } cmd_t;

  // True while another attempt may still be made after tries NACKs.
  function automatic logic retry_allowed(input logic [1:0] tries);
    return (int'(tries) < RETRY_LIMIT);
  endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// i2c_cmd_sequencer_if
// Bundles the host command port and the I2C engine handshake.
//   cmd_data/cmd_wr     : host command word and push strobe
//   cmd_full/cmd_count  : command FIFO status back to the host
//   PCDATA/STARTW       : command word and start level to the I2C engine
//   i2c_busy/i2c_nack   : engine status
// master = sequencer view, slave = host/engine view.
interface i2c_cmd_sequencer_if #(
  parameter int DEPTH = 8
);

  logic [31:0]              cmd_data;
  logic                     cmd_wr;
  logic                     cmd_full;
  logic [$clog2(DEPTH):0]   cmd_count;
  logic [31:0]              PCDATA;
  logic                     STARTW;
  logic                     i2c_busy;
  logic                     i2c_nack;

  modport master (
    input  cmd_data, cmd_wr, i2c_busy, i2c_nack,
    output cmd_full, cmd_count, PCDATA, STARTW
  );

  modport slave (
    output cmd_data, cmd_wr, i2c_busy, i2c_nack,
    input  cmd_full, cmd_count, PCDATA, STARTW
  );

endinterface

// File: rtl/i2c_seq_fifo.sv
// i2c_seq_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk, reset : system clock, synchronous active-high reset
//   flush      : empties the FIFO (takes priority over push)
//   push, din  : write request and data; dropped when full unless a pop
//                happens in the same cycle
//   pop, dout  : read request; dout always shows the head entry
//   full, empty, count : occupancy status
module i2c_seq_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CMD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  assign dout  = mem[rd_ptr];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer
// Queues 32-bit host commands and feeds them one at a time to an I2C
// engine: latch the head into PCDATA, hold STARTW until the engine goes
// busy, wait for busy to fall, check NACK, then idle GAP_CYCLES before
// the next command. A NACK or a start that is never accepted within
// ACK_TIMEOUT cycles parks the sequencer in ERROR until reset.
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : i2c_cmd_sequencer_if.master (host command + engine)
//   done_count  : completed transactions, wraps at 16 bits
//   err         : sticky error flag
//   seq_state   : current FSM state code
// Optional feature macro I2C_SEQ_RETRY_EN: a NACKed command is re-issued
// after the gap, up to RETRY_LIMIT times, before falling into ERROR.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int GAP_CYCLES  = 1000,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_cmd_sequencer_if.master  bus,
  output logic [15:0]          done_count,
  output logic                 err,
  output logic [2:0]           seq_state
);

  seq_state_e  state_q;
  seq_state_e  state_d;
  cmd_t        pcdata_q;
  logic [31:0] timer_q;
  logic [15:0] done_q;
  logic        err_q;

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        fifo_empty;
  logic [31:0] fifo_dout;

  logic        timer_clr;
  logic        done_inc;
  logic        err_set;

`ifdef I2C_SEQ_RETRY_EN
  logic [1:0]  retry_q;
  logic        retry_inc;
  logic        retry_clr;
`endif

  // Host writes are ignored once the sequencer has failed.
  assign fifo_push = bus.cmd_wr && (state_q != ST_ERROR);

  i2c_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (bus.cmd_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (bus.cmd_full),
    .empty (fifo_empty),
    .count (bus.cmd_count)
  );

  assign bus.PCDATA = pcdata_q;
  assign bus.STARTW = (state_q == ST_ISSUE);
  assign done_count = done_q;
  assign err        = err_q;
  assign seq_state  = state_q;

  // Next-state and control decode. RUN is only entered after busy was
  // seen high, so busy low in RUN is the falling edge; busy already high
  // on ISSUE entry is taken as acceptance straight away.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    timer_clr  = 1'b0;
    done_inc   = 1'b0;
    err_set    = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          timer_clr = 1'b1;
          state_d   = ST_ISSUE;
`ifdef I2C_SEQ_RETRY_EN
          retry_clr = 1'b1;
`endif
        end
      end
      ST_ISSUE: begin
        if (bus.i2c_busy) begin
          timer_clr = 1'b1;
          state_d   = ST_RUN;
        end else if (timer_q >= 32'(ACK_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_RUN: begin
        if (!bus.i2c_busy) begin
          timer_clr = 1'b1;
          if (!bus.i2c_nack) begin
            done_inc = 1'b1;
            state_d  = ST_GAP;
`ifdef I2C_SEQ_RETRY_EN
            retry_clr = 1'b1;
`endif
          end else begin
`ifdef I2C_SEQ_RETRY_EN
            if (retry_allowed(retry_q)) begin
              retry_inc = 1'b1;
              state_d   = ST_GAP;
            end else begin
              err_set = 1'b1;
              state_d = ST_ERROR;
            end
`else
            err_set = 1'b1;
            state_d = ST_ERROR;
`endif
          end
        end
      end
      ST_GAP: begin
        if (timer_q >= 32'(GAP_CYCLES - 1)) begin
          timer_clr = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
          // A non-zero retry count here means the last attempt NACKed.
          state_d = (retry_q != 2'd0) ? ST_ISSUE : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_ERROR: begin
        fifo_flush = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched command, shared ISSUE/GAP timer, counters and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pcdata_q <= '0;
      timer_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        pcdata_q <= fifo_dout;
      end
      if (timer_clr) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 32'd1;
      end
      if (done_inc) begin
        done_q <= done_q + 16'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  // Counts NACKed attempts of the current command.
  always_ff @(posedge clk) begin
    if (reset || retry_clr) begin
      retry_q <= 2'd0;
    end else if (retry_inc) begin
      retry_q <= retry_q + 2'd1;
    end
  end
`endif

endmodule
